mlp_layer_sequencer: RTL and testbench
======================================

# mlp_layer_sequencer

Sequences one fully-connected MLP layer over the ping-pong activation buffers and the shared weight memory. For each output neuron it clears the MAC, streams every input activation and its weight, drains the pipeline, applies the activation function and writes the result to the output buffer. When all neurons are written it pulses `swap` so the buffer controller exchanges read and write banks. The block sits between the top-level layer scheduler (`start`/`done`) and the buffer/weight/MAC datapath.

## Interface
- `ADDR_W`, 8: activation buffer address width (max 256 inputs/outputs)
- `WADDR_W`, 16: weight memory address width
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: layer start request; sampled only in IDLE
- `n_in_m1` in ADDR_W: number of inputs minus 1; latched at start
- `n_out_m1` in ADDR_W: number of neurons minus 1; latched at start
- `buf_ready` in 1: input bank holds valid data
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at layer completion
- `swap` out 1: one-cycle pulse, coincident with `done`
- `buf_rd_en` out 1: input buffer read strobe
- `buf_rd_addr` out ADDR_W: input index i
- `w_rd_en` out 1: weight memory read strobe
- `w_addr` out WADDR_W: running weight address
- `mac_clr` out 1: clear accumulator
- `mac_en` out 1: accumulate the current data/weight pair
- `bias_sel` out 1: MAC data operand is constant 1 (bias term)
- `act_en` out 1: register the activation of the accumulator
- `out_wr_en` out 1: output buffer write strobe
- `out_wr_addr` out ADDR_W: neuron index j

## Operation
- States: IDLE, WAIT, CLEAR, MAC, DRAIN, ACT, WRITE, DONE.
- IDLE: when `start`=1, latch `n_in_m1`/`n_out_m1`, set i=0, j=0, `w_addr`=0, go to WAIT. `start` in any other state is ignored.
- WAIT: stay until `buf_ready`=1, then go to CLEAR. `buf_ready` is not checked after WAIT.
- CLEAR: `mac_clr`=1 for one cycle, i=0, then go to MAC.
- MAC: every cycle `buf_rd_en`=`w_rd_en`=1, `buf_rd_addr`=i, `w_addr` increments after each read.
  - If i==`n_in_m1`, go to DRAIN; otherwise i++.
- DRAIN: no reads. Covers the final accumulate. Go to ACT.
- ACT: `act_en`=1 for one cycle, then go to WRITE.
- WRITE: `out_wr_en`=1, `out_wr_addr`=j.
  - If j==`n_out_m1`, go to DONE; otherwise j++ and go to CLEAR.
- DONE: `done`=`swap`=1 for one cycle, then go to IDLE.
- `w_addr` is never reset between neurons. Layout is row-major; it wraps modulo 2^WADDR_W with no flag.
- Reset (any state, including mid-layer): state goes to IDLE and all counters and outputs go to 0. The partial layer is discarded and no `done` is issued.

## Timing
- Memories have 1-cycle read latency. `mac_en` (and `bias_sel`) is the registered copy of `w_rd_en` (and the bias read flag), so it is high the cycle after each read.
- First read is on the cycle after CLEAR. Last `mac_en` falls in DRAIN. `act_en` is one cycle after DRAIN. Write happens in the following cycle.
- Cycles per neuron: n_in+4, where n_in=`n_in_m1`+1.
- Total time: `done` is high in the cycle starting at edge 2+(`n_out_m1`+1)·(n_in+4), counted from the `start`-sampling edge, with `buf_ready` high throughout.
- `n_in_m1`=0 is valid: one MAC cycle. `n_out_m1`=0 is valid: one neuron.
- `done`/`swap` are registered outputs. A new `start` is accepted in the cycle after DONE at the earliest.

## Configuration
- `MLP_BIAS_EN` defined: MAC performs one extra read per neuron after input `n_in_m1`. On that read `buf_rd_en`=0, `w_rd_en`=1, `w_addr` increments, and `bias_sel`=1 on the matching `mac_en` cycle. Per-neuron cost becomes n_in+5. Weight rows are n_in+1 words.
- `MLP_BIAS_EN` undefined: no bias read occurs, and `bias_sel` is tied to 0.

## Test plan
- Reset: drive `rst`=0 at an arbitrary state, then release. All outputs are 0, the state is IDLE and `busy`=0.
- Basic layer: `n_in_m1`=3, `n_out_m1`=1, `buf_ready`=1, bias off. `w_addr` reads 0..7, `out_wr_addr` writes 0 then 1, and `done`/`swap` pulse exactly once at edge 18.
- WAIT stall: hold `buf_ready`=0 for 5 cycles after start. No read or `mac_clr` occurs, and `done` is delayed by exactly 5 cycles.
- Minimum size: `n_in_m1`=0, `n_out_m1`=0. There is one read at address 0, `mac_en` is high for one cycle and `done` is at edge 7.
- Bias (`MLP_BIAS_EN`): `n_in_m1`=1, `n_out_m1`=1. Weight reads are 0..5, `bias_sel`=1 on the 3rd and 6th `mac_en` cycles, and `done` is at edge 16.
- Abuse: pulse `start` while busy, then assert `rst` mid-MAC. The start is ignored, there is no `done`, and a restart from IDLE completes normally with `w_addr` beginning at 0.

Source files
------------

// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for one fully-connected MLP layer: CLEAR/MAC/DRAIN/ACT/WRITE per neuron.
// Optional bias read per neuron is enabled by defining MLP_BIAS_EN.
module mlp_layer_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int WADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  n_in_m1,
  input  logic [ADDR_W-1:0]  n_out_m1,
  input  logic               buf_ready,
  output logic               busy,
  output logic               done,
  output logic               swap,
  output logic               buf_rd_en,
  output logic [ADDR_W-1:0]  buf_rd_addr,
  output logic               w_rd_en,
  output logic [WADDR_W-1:0] w_addr,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               bias_sel,
  output logic               act_en,
  output logic               out_wr_en,
  output logic [ADDR_W-1:0]  out_wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_CLEAR, S_MAC, S_DRAIN, S_ACT, S_WRITE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    i_q, i_d;
  logic [ADDR_W-1:0]    j_q, j_d;
  logic [ADDR_W-1:0]    n_in_q, n_in_d;
  logic [ADDR_W-1:0]    n_out_q, n_out_d;
  logic [WADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                 rd_vld_p1_q, rd_vld_p1_d;
  logic                 done_q, done_d;
  logic                 rd_buf, rd_w, clr, act, wr;
`ifdef MLP_BIAS_EN
  logic                 bias_ph_q, bias_ph_d;
  logic                 bias_p1_q, bias_p1_d;
  logic                 rd_bias;
`endif

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    w_addr_d    = w_addr_q;
    rd_buf      = 1'b0;
    rd_w        = 1'b0;
    clr         = 1'b0;
    act         = 1'b0;
    wr          = 1'b0;
`ifdef MLP_BIAS_EN
    bias_ph_d   = bias_ph_q;
    rd_bias     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_in_d   = n_in_m1;
          n_out_d  = n_out_m1;
          i_d      = '0;
          j_d      = '0;
          w_addr_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (buf_ready) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr     = 1'b1;
        i_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        // Weight address runs continuously across neurons (row-major rows).
        rd_w     = 1'b1;
        w_addr_d = w_addr_q + WADDR_W'(1);
`ifdef MLP_BIAS_EN
        if (bias_ph_q) begin
          rd_bias   = 1'b1;
          bias_ph_d = 1'b0;
          state_d   = S_DRAIN;
        end else begin
          rd_buf = 1'b1;
          if (i_q == n_in_q) bias_ph_d = 1'b1;
          else               i_d       = i_q + ADDR_W'(1);
        end
`else
        rd_buf = 1'b1;
        if (i_q == n_in_q) state_d = S_DRAIN;
        else               i_d     = i_q + ADDR_W'(1);
`endif
      end
      S_DRAIN: state_d = S_ACT;
      S_ACT: begin
        act     = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        wr = 1'b1;
        if (j_q == n_out_q) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + ADDR_W'(1);
          state_d = S_CLEAR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_vld_p1_d = rd_w;
    done_d      = (state_q == S_DONE);
`ifdef MLP_BIAS_EN
    bias_p1_d   = rd_bias;
`endif
  end

  // p1: memory read latency stage; MAC strobes follow the read by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      n_in_q      <= '0;
      n_out_q     <= '0;
      w_addr_q    <= '0;
      rd_vld_p1_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef MLP_BIAS_EN
      bias_ph_q   <= 1'b0;
      bias_p1_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      w_addr_q    <= w_addr_d;
      rd_vld_p1_q <= rd_vld_p1_d;
      done_q      <= done_d;
`ifdef MLP_BIAS_EN
      bias_ph_q   <= bias_ph_d;
      bias_p1_q   <= bias_p1_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign swap        = done_q;
  assign buf_rd_en   = rd_buf;
  assign buf_rd_addr = i_q;
  assign w_rd_en     = rd_w;
  assign w_addr      = w_addr_q;
  assign mac_clr     = clr;
  assign mac_en      = rd_vld_p1_q;
  assign act_en      = act;
  assign out_wr_en   = wr;
  assign out_wr_addr = j_q;
`ifdef MLP_BIAS_EN
  assign bias_sel    = bias_p1_q;
`else
  assign bias_sel    = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench for mlp_layer_sequencer: per-cycle schedule model plus literal pins on layer timing.
module tb_mlp_layer_sequencer;

`ifdef MLP_BIAS_EN
  localparam int BIAS = 1;
`else
  localparam int BIAS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  n_in_m1 = '0;
  logic [7:0]  n_out_m1 = '0;
  logic        buf_ready = 1'b0;
  logic        busy, done, swap, buf_rd_en, w_rd_en, mac_clr, mac_en, bias_sel, act_en, out_wr_en;
  logic [7:0]  buf_rd_addr, out_wr_addr;
  logic [15:0] w_addr;

  mlp_layer_sequencer #(.ADDR_W(8), .WADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in_m1(n_in_m1), .n_out_m1(n_out_m1),
    .buf_ready(buf_ready), .busy(busy), .done(done), .swap(swap),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .w_rd_en(w_rd_en), .w_addr(w_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .bias_sel(bias_sel), .act_en(act_en),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Driver-owned model controls: mode 0 = no check, 1 = layer schedule, 2 = all outputs zero.
  int m_mode = 0;
  int m_base, m_w, m_nin, m_nout;
  int l_done, l_rd, l_mac, l_bsel, l_last;
  int to_cnt = 0;

  // Compare-process-owned counters.
  int pass_cnt = 0, chk_cnt = 0, to_seen = 0;
  int rd_cnt, mac_cnt, bsel_cnt, first_wa, last_wa;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, edge_cnt);
  endtask

  // Expected outputs for cycle k after the start-sampling edge, from the layer schedule.
  function automatic void model(input int k, output logic [9:0] ev,
                                output int eba, output int ewa, output int eoa);
    int r_per, per, c0, endk, j, o;
    r_per = m_nin + BIAS;
    per   = r_per + 4;
    c0    = 1 + m_w;
    endk  = c0 + m_nout * per;
    ev = '0; eba = 0; ewa = 0; eoa = 0;
    ev[9] = (k <= endk);
    ev[8] = (k == endk + 1);
    ev[7] = (k == endk + 1);
    if (k >= c0 && k < endk) begin
      j = (k - c0) / per;
      o = (k - c0) % per;
      ev[4] = (o == 0);
      if (o >= 1 && o <= r_per) begin
        ev[5] = 1'b1;
        ev[6] = (o - 1 < m_nin);
        eba   = o - 1;
        ewa   = (j * r_per + o - 1) % 65536;
      end
      ev[3] = (o >= 2 && o <= r_per + 1);
      ev[2] = (BIAS != 0) && (o == r_per + 1);
      ev[1] = (o == r_per + 2);
      ev[0] = (o == r_per + 3);
      eoa   = j;
    end
  endfunction

  always @(negedge clk) begin : cmp
    logic [9:0] av, ev;
    int k, eba, ewa, eoa;
    bit ok;
    av = {busy, done, swap, buf_rd_en, w_rd_en, mac_clr, mac_en, bias_sel, act_en, out_wr_en};
    if (to_cnt != to_seen) begin
      to_seen = to_cnt;
      chk(1'b0, "done_timeout", 0, 1);
    end
    if (m_mode == 2) begin
      ok = (av == '0) && (buf_rd_addr == 8'd0) && (w_addr == 16'd0) && (out_wr_addr == 8'd0);
      chk(ok, "idle_zero", {av, buf_rd_addr, w_addr, out_wr_addr}, 0);
    end else if (m_mode == 1) begin
      k = edge_cnt - m_base;
      if (k == 0) begin
        rd_cnt = 0; mac_cnt = 0; bsel_cnt = 0; first_wa = -1; last_wa = -1;
      end
      model(k, ev, eba, ewa, eoa);
      if (!ev[6]) eba = buf_rd_addr;
      if (!ev[5]) ewa = w_addr;
      if (!ev[0]) eoa = out_wr_addr;
      ok = (av == ev) && (buf_rd_addr == eba[7:0]) && (w_addr == ewa[15:0]) && (out_wr_addr == eoa[7:0]);
      chk(ok, $sformatf("cycle_k%0d", k), {av, buf_rd_addr, w_addr, out_wr_addr},
          {ev, eba[7:0], ewa[15:0], eoa[7:0]});
      if (w_rd_en) begin
        if (rd_cnt == 0) first_wa = w_addr;
        last_wa = w_addr;
        rd_cnt++;
      end
      if (mac_en) mac_cnt++;
      if (bias_sel) bsel_cnt++;
      if (done) begin
        chk(k == l_done, "done_edge", k, l_done);
        chk(rd_cnt == l_rd, "w_read_count", rd_cnt, l_rd);
        chk(mac_cnt == l_mac, "mac_en_count", mac_cnt, l_mac);
        chk(bsel_cnt == l_bsel, "bias_sel_count", bsel_cnt, l_bsel);
        chk(first_wa == 0, "first_w_addr", first_wa, 0);
        chk(last_wa == l_last, "last_w_addr", last_wa, l_last);
      end
    end
  end

  task automatic run_layer(input int nin, input int nout, input int stall,
                           input int ld, input int lrd, input int lmac, input int lbs, input int llast);
    bit got;
    @(posedge clk); #1;
    n_in_m1   = nin[7:0];
    n_out_m1  = nout[7:0];
    buf_ready = (stall == 0);
    start     = 1'b1;
    l_done = ld; l_rd = lrd; l_mac = lmac; l_bsel = lbs; l_last = llast;
    @(posedge clk); #1;
    start  = 1'b0;
    m_base = edge_cnt;
    m_w    = stall;
    m_nin  = nin + 1;
    m_nout = nout + 1;
    m_mode = 1;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 buf_ready = 1'b1;
    end
    got = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) to_cnt++;
    repeat (2) begin
      @(posedge clk); #1;
    end
    m_mode = 0;
  endtask

  initial begin : drv
    // Reset from power-up, outputs must read zero while held and after release.
    #2 rst = 1'b0;
    m_mode = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 m_mode = 0;

    // Basic layer: 4 inputs, 2 neurons.
    run_layer(3, 1, 0, 18 + 2 * BIAS, 8 + 2 * BIAS, 8 + 2 * BIAS, 2 * BIAS, 7 + 2 * BIAS);
    // WAIT stall of 5 cycles delays completion by exactly 5.
    run_layer(3, 1, 5, 23 + 2 * BIAS, 8 + 2 * BIAS, 8 + 2 * BIAS, 2 * BIAS, 7 + 2 * BIAS);
    // Minimum layer: 1 input, 1 neuron.
    run_layer(0, 0, 0, 7 + BIAS, 1 + BIAS, 1 + BIAS, BIAS, BIAS);
`ifdef MLP_BIAS_EN
    run_layer(1, 1, 0, 16, 6, 6, 2, 5);
`endif

    // Abuse: start pulsed while busy with different sizes, then reset mid-MAC.
    @(posedge clk); #1;
    n_in_m1 = 8'd3; n_out_m1 = 8'd1; buf_ready = 1'b1; start = 1'b1;
    l_done = -1; l_rd = -1; l_mac = -1; l_bsel = -1; l_last = -1;
    @(posedge clk); #1;
    start = 1'b0; m_base = edge_cnt; m_w = 0; m_nin = 4; m_nout = 2; m_mode = 1;
    @(posedge clk); #1;
    start = 1'b1; n_in_m1 = 8'd0; n_out_m1 = 8'd0;
    @(posedge clk); #1;
    start = 1'b0; n_in_m1 = 8'd3; n_out_m1 = 8'd1;
    @(posedge clk); #1;
    rst = 1'b0; m_mode = 2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 m_mode = 0;

    // Restart from IDLE completes normally with weights from address 0.
    run_layer(3, 1, 0, 18 + 2 * BIAS, 8 + 2 * BIAS, 8 + 2 * BIAS, 2 * BIAS, 7 + 2 * BIAS);

    repeat (2) @(posedge clk);
    #1 $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
